// File: rtl/uart_pkg.sv
// Shared definitions for the console UART receive path.
// Holds the ASCII constants, the receiver state encoding, the bit-counter
// width helper and the ASCII-to-nibble decode (inverse of hex_to_ascii).
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_a  = 8'h61;
  localparam logic [7:0] ASCII_f  = 8'h66;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Width of a counter that must hold 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns {is_hex, nibble}; is_hex is 0 for any non-hex character.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [7:0] d;
    d = 8'h00;
    if (c >= ASCII_0 && c <= ASCII_9) begin
      d = c - ASCII_0;
      return {1'b1, d[3:0]};
    end
    if (c >= ASCII_A && c <= ASCII_F) begin
      d = c - ASCII_A + 8'd10;
      return {1'b1, d[3:0]};
    end
    if (c >= ASCII_a && c <= ASCII_f) begin
      d = c - ASCII_a + 8'd10;
      return {1'b1, d[3:0]};
    end
    return 5'b0_0000;
  endfunction

endpackage

// File: rtl/uart_in.sv
// 8N1 UART receiver: 2-flop synchroniser plus receive FSM.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   line        - raw serial input, idle high, asynchronous to clk
//   rx_byte     - last accepted byte
//   byte_valid  - one-cycle strobe, the cycle after a good stop-bit sample
//   frame_err   - one-cycle strobe, the cycle after a low stop-bit sample
//   busy        - high whenever the FSM is not IDLE
module uart_in
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1;
  logic            sync2;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            brk;
  logic [1:0]      primed;
  logic            armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
    end
  end

  // primed/armed: the synchroniser resets to 1, so a high value is only
  // trusted once real line samples have flushed through both flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      brk        <= 1'b0;
      primed     <= '0;
      armed      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      primed     <= {primed[0], 1'b1};
      case (state)
        IDLE: begin
          if (!armed) begin
            if (primed[1] && sync2) armed <= 1'b1;
          end else if (!sync2) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (sync2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[7:1]};
            if (idx == 3'd7) state <= STOP;
            else idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (brk) begin
            // Hold off re-arming until a break has ended.
            if (sync2) begin
              brk   <= 1'b0;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == LAST) begin
            cnt <= '0;
            if (sync2) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_rx.sv
// Console hex receiver: decodes ASCII hex digits from a UART line and
// packs four of them, most significant first, into a 16-bit word.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   in          - UART serial line, idle high
//   data        - last completed word, held until the next one completes
//   data_valid  - one-cycle pulse when data updates
//   err         - one-cycle pulse on framing error or illegal character
//   busy        - a frame is being received
module uart_hex_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        err,
  output logic        busy
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;
  logic [1:0]  digits;
  // Only three digits are ever pending; the fourth goes straight to data.
  logic [11:0] acc;
  logic [4:0]  dec;

  uart_in #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .line       (in),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always_comb begin
    dec = ascii_to_nibble(rx_byte);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      digits     <= '0;
      acc        <= '0;
    end else begin
      data_valid <= 1'b0;
      err        <= 1'b0;
      if (frame_err) begin
        err    <= 1'b1;
        digits <= '0;
        acc    <= '0;
      end else if (byte_valid) begin
        if (dec[4]) begin
          if (digits == 2'd3) begin
            data       <= {acc, dec[3:0]};
            data_valid <= 1'b1;
            digits     <= '0;
            acc        <= '0;
          end else begin
            acc    <= {acc[7:0], dec[3:0]};
            digits <= digits + 1'b1;
          end
        end else begin
          digits <= '0;
          acc    <= '0;
          if (rx_byte != ASCII_CR && rx_byte != ASCII_LF) err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_hex_rx.md
# uart_hex_rx

Receive-side counterpart of the console hex transmit path. Deserialises 8N1 UART frames from the console line and decodes ASCII hex characters '0'–'9', 'A'–'F' and 'a'–'f'. Packs four digits, most significant first, into a 16-bit word and presents it with a one-cycle valid pulse. Sits between the board RX pin and any register or command logic that consumes 16-bit values typed at the console.

## Interface
- CLKS_PER_BIT, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 4.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  1  UART serial line, idle high, asynchronous to clk.
- data  out  16  last completed word; reset 16'h0000; holds until the next word completes.
- data_valid  out  1  one-cycle pulse when data is updated; reset 0.
- err  out  1  one-cycle pulse on framing error or illegal character; reset 0.
- busy  out  1  high while a frame is being received (FSM not IDLE); reset 0.

## Operation
- Line conditioning:
  - in passes through a 2-flop synchroniser; both flops reset to 1.
  - The FSM sees only the synchronised value.
- Receiver FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive the sampling points.
  - IDLE: a synchronised low starts a frame; go to START and clear the bit counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample the line.
    - Low: go to DATA.
    - High: treat as a glitch; return to IDLE with no err.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High: byte accepted.
    - Low: framing error. Pulse err, drop the byte, clear the digit count, then wait in STOP until the line is high before entering IDLE (no false start on a break).
  - The FSM returns to IDLE on the cycle after the stop-bit sample.
- Character decode (on each accepted byte):
  - Hex digit: acc ← {acc[11:0], nibble}; digit count increments.
  - 0x0D (CR) or 0x0A (LF): clear digit count and acc silently; no err.
  - Any other byte: clear digit count and acc; pulse err.
- Word completion: when the 4th digit is decoded, set data to the completed value, pulse data_valid, and clear digit count and acc. There is no back-pressure; the consumer must capture data on data_valid or read the held value.
- A 5th digit starts a new word.
- err and data_valid are never asserted in the same cycle.
- Reset mid-frame: all state returns to reset values immediately. The remainder of the interrupted frame is ignored: the FSM re-arms only after the line has been seen high for one synchronised cycle.

## Timing
- Synchroniser latency: 2 cycles from a pin edge.
- Start-bit midpoint sample: CLKS_PER_BIT/2 cycles after the falling edge is seen. Each subsequent sample is a further CLKS_PER_BIT cycles.
- Byte-accepted strobe (internal): the cycle after the stop-bit sample.
- data_valid / err pulse: the cycle after the byte-accepted strobe, i.e. 2 cycles after the stop-bit sample.
- Back-to-back frames, with the next start bit immediately after the stop midpoint, must be received without loss.
- Pulses are exactly 1 cycle wide.

## Structure
- Shared package uart_pkg holds:
  - ASCII constants: ASCII_0, ASCII_9, ASCII_A, ASCII_F, ASCII_a, ASCII_f, ASCII_CR, ASCII_LF.
  - The receiver state enum {IDLE, START, DATA, STOP}.
  - The bit-count width helper.
- Sub-module uart_in: synchroniser plus receiver FSM, producing byte[7:0], byte_valid and frame_err. Mirrors the existing transmit module.
- The ASCII-to-nibble decode is a combinational function in uart_pkg, the inverse of the existing hex_to_ascii.
- The top level contains word assembly only.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Send "1A2f" back-to-back → exactly one data_valid; data=16'h1A2F; err never asserted.
- Send "12", CR, "BEEF" → one data_valid with data=16'hBEEF; no err.
- Send 'G' (0x47) after "3" → one err pulse; then "0042" → data=16'h0042.
- Frame with stop bit low, then line held low for 20 bits, then "ABCD" → one err, no spurious bytes, then data=16'hABCD.
- 3-cycle low glitch on in → busy returns to 0 with no err and no data_valid.
- Assert rst_n low during data bit 4 of the 2nd digit, release, then send "9999" → data=16'h9999; all outputs 0 during reset.
